// File: rtl/dn_ib_ram_reader_if.sv
// Lookup bus between the decoder (master) and the IB-RAM reader (slave).
// Carries the table index request and the 1-bit result/drop flags.
interface dn_ib_ram_reader_if #(
    parameter int SEL_BW       = 1,
    parameter int PAGE_ADDR_BW = 6
) ();
    localparam int IDX_BW = PAGE_ADDR_BW + SEL_BW;

    logic              lut_req;
    logic [IDX_BW-1:0] lut_idx;
    logic              lut_valid;
    logic              lut_bit;
    logic              lut_drop;

    modport master (
        output lut_req,
        output lut_idx,
        input  lut_valid,
        input  lut_bit,
        input  lut_drop
    );

    modport slave (
        input  lut_req,
        input  lut_idx,
        output lut_valid,
        output lut_bit,
        output lut_drop
    );
endinterface

// File: rtl/dn_ib_ram_reader.sv
// Read-side controller for the double-buffered decision-node IB-RAM.
// Define DN_READ_OUTREG_EN to add the lookup output register (latency 2 instead of 1).
module dn_ib_ram_reader #(
    parameter  int SEL_BW       = 1,
    parameter  int PAGE_ADDR_BW = 6,
    parameter  int ITER_ADDR_BW = 6,
    parameter  int MAX_ITER     = 50,
    localparam int ROM_RD_BW    = 2**SEL_BW
) (
    input  logic                    write_clk,
    input  logic                    rstn,
    input  logic                    wr_iter_finish,
    output logic                    wr_bank,
    output logic                    wr_stall,
    output logic                    iter_ready,
    input  logic                    iter_start,
    input  logic                    iter_end,
    dn_ib_ram_reader_if.slave       lut,
    output logic                    ram_rd_en,
    output logic [PAGE_ADDR_BW:0]   ram_rd_addr,
    input  logic [ROM_RD_BW-1:0]    ram_rd_data,
    output logic [ITER_ADDR_BW-1:0] rd_iter_cnt,
    output logic                    decode_done
);
    localparam int IDX_BW = PAGE_ADDR_BW + SEL_BW;

    typedef enum logic [1:0] {IDLE, READY, ACTIVE, DONE} state_t;

    state_t            state;
    logic              fin_q;
    logic              fin_qq;
    logic              set_full;
    logic [1:0]        full;
    logic [1:0]        set_mask;
    logic [1:0]        clr_mask;
    logic              rd_bank;
    logic              iter_end_acc;
    logic              other_full;
    logic              req_ok;
    logic              req_q;
    logic [SEL_BW-1:0] sel_q;

    assign set_full     = fin_q & ~fin_qq;
    assign iter_end_acc = (state == ACTIVE) && iter_end;
    assign set_mask     = set_full     ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask     = iter_end_acc ? (2'b01 << rd_bank) : 2'b00;
    // A bank being filled in the same cycle as iter_end still counts as ready.
    assign other_full   = full[~rd_bank] | set_mask[~rd_bank];

    assign wr_stall    = full[wr_bank];
    assign iter_ready  = (state == READY);
    assign decode_done = (state == DONE);

    assign req_ok      = lut.lut_req && (state == ACTIVE);
    assign ram_rd_en   = req_ok;
    assign ram_rd_addr = req_ok ? {rd_bank, lut.lut_idx[IDX_BW-1:SEL_BW]} : '0;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            fin_q       <= 1'b0;
            fin_qq      <= 1'b0;
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            rd_iter_cnt <= '0;
        end else begin
            fin_q  <= wr_iter_finish;
            fin_qq <= fin_q;
            full   <= (full | set_mask) & ~clr_mask;
            if (set_full) begin
                wr_bank <= ~wr_bank;
            end
            if (iter_end_acc) begin
                rd_bank <= ~rd_bank;
                if (rd_iter_cnt < ITER_ADDR_BW'(MAX_ITER)) begin
                    rd_iter_cnt <= rd_iter_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (iter_start) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (iter_end) begin
                        if (rd_iter_cnt == ITER_ADDR_BW'(MAX_ITER - 1)) begin
                            state <= DONE;
                        end else if (other_full) begin
                            state <= READY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

    // The bank lives in the issued address, so only the select needs to follow the request.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            req_q        <= 1'b0;
            sel_q        <= '0;
            lut.lut_drop <= 1'b0;
        end else begin
            req_q <= req_ok;
            if (req_ok) begin
                sel_q <= lut.lut_idx[SEL_BW-1:0];
            end
            if (lut.lut_req && (state != ACTIVE)) begin
                lut.lut_drop <= 1'b1;
            end
        end
    end

`ifdef DN_READ_OUTREG_EN
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            lut.lut_valid <= 1'b0;
            lut.lut_bit   <= 1'b0;
        end else begin
            lut.lut_valid <= req_q;
            lut.lut_bit   <= req_q & ram_rd_data[sel_q];
        end
    end
`else
    assign lut.lut_valid = req_q;
    assign lut.lut_bit   = req_q & ram_rd_data[sel_q];
`endif
endmodule

// File: tb/tb_dn_ib_ram_reader.sv
// Directed self-checking bench for dn_ib_ram_reader; follows DN_READ_OUTREG_EN for lookup latency.
module tb_dn_ib_ram_reader;
    localparam int SEL_BW       = 1;
    localparam int PAGE_ADDR_BW = 6;
    localparam int ITER_ADDR_BW = 6;
    localparam int MAX_ITER     = 50;
`ifdef DN_READ_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                    write_clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    wr_iter_finish = 1'b0;
    logic                    iter_start = 1'b0;
    logic                    iter_end = 1'b0;
    logic                    wr_bank;
    logic                    wr_stall;
    logic                    iter_ready;
    logic                    ram_rd_en;
    logic [PAGE_ADDR_BW:0]   ram_rd_addr;
    logic [1:0]              ram_rd_data = 2'b00;
    logic [ITER_ADDR_BW-1:0] rd_iter_cnt;
    logic                    decode_done;
    logic [1:0]              mem [0:127];
    logic                    exp_wr_bank;
    int                      tests = 0;
    int                      fails = 0;

    dn_ib_ram_reader_if #(.SEL_BW(SEL_BW), .PAGE_ADDR_BW(PAGE_ADDR_BW)) lut_bus ();

    dn_ib_ram_reader #(
        .SEL_BW(SEL_BW), .PAGE_ADDR_BW(PAGE_ADDR_BW),
        .ITER_ADDR_BW(ITER_ADDR_BW), .MAX_ITER(MAX_ITER)
    ) dut (
        .write_clk(write_clk), .rstn(rstn), .wr_iter_finish(wr_iter_finish),
        .wr_bank(wr_bank), .wr_stall(wr_stall), .iter_ready(iter_ready),
        .iter_start(iter_start), .iter_end(iter_end), .lut(lut_bus),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .rd_iter_cnt(rd_iter_cnt), .decode_done(decode_done)
    );

    always #5 write_clk = ~write_clk;

    // IB-RAM model: synchronous read, data one cycle after the enable.
    always @(posedge write_clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [6:0] idx, input logic start,
                                 input logic iend, input logic fin);
        @(posedge write_clk);
        #1;
        lut_bus.lut_req = req;
        lut_bus.lut_idx = idx;
        iter_start      = start;
        iter_end        = iend;
        wr_iter_finish  = fin;
        @(negedge write_clk);
    endtask

    task automatic writerPulse();
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        exp_wr_bank = ~exp_wr_bank;
        checkOutput("wr_bank_after_fill", wr_bank, exp_wr_bank);
    endtask

    task automatic lookupWindow(input string tag, input logic exp_bit);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput({tag, "_valid"}, lut_bus.lut_valid, k == LAT);
            checkOutput({tag, "_bit"}, lut_bus.lut_bit, (k == LAT) ? exp_bit : 1'b0);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wr_bank"}, wr_bank, 0);
        checkOutput({tag, "_wr_stall"}, wr_stall, 0);
        checkOutput({tag, "_iter_ready"}, iter_ready, 0);
        checkOutput({tag, "_lut_valid"}, lut_bus.lut_valid, 0);
        checkOutput({tag, "_lut_bit"}, lut_bus.lut_bit, 0);
        checkOutput({tag, "_lut_drop"}, lut_bus.lut_drop, 0);
        checkOutput({tag, "_ram_rd_en"}, ram_rd_en, 0);
        checkOutput({tag, "_ram_rd_addr"}, ram_rd_addr, 0);
        checkOutput({tag, "_rd_iter_cnt"}, rd_iter_cnt, 0);
        checkOutput({tag, "_decode_done"}, decode_done, 0);
    endtask

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = 2'b00;
        mem[5]  = 2'b10;
        mem[69] = 2'b01;
        lut_bus.lut_req = 1'b0;
        lut_bus.lut_idx = '0;
        exp_wr_bank     = 1'b0;

        // Reset state
        @(negedge write_clk);
        @(negedge write_clk);
        checkResetOutputs("reset");
        @(posedge write_clk);
        #1 rstn = 1'b1;

        // Single writer completion: full[0] at T+2, READY at T+3
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wr_bank_t1", wr_bank, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wr_bank_t2", wr_bank, 1);
        checkOutput("iter_ready_t2", iter_ready, 0);
        checkOutput("wr_stall_t2", wr_stall, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("iter_ready_t3", iter_ready, 1);
        checkOutput("rd_iter_cnt_t3", rd_iter_cnt, 0);
        exp_wr_bank = 1'b1;

        // Both banks full: writer must stall on bank 0
        writerPulse();
        checkOutput("wr_stall_both_full", wr_stall, 1);

        // Start iteration, back-to-back lookups from bank 0 page 5 (word 2'b10)
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("iter_ready_before_start", iter_ready, 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k < 2, (k == 0) ? 7'd11 : 7'd10, 0, 0, 0);
            checkOutput("b2b_rd_en", ram_rd_en, k < 2);
            checkOutput("b2b_rd_addr", ram_rd_addr, (k < 2) ? 5 : 0);
            checkOutput("b2b_valid", lut_bus.lut_valid, (k == LAT) || (k == LAT + 1));
            checkOutput("b2b_bit", lut_bus.lut_bit, k == LAT);
        end

        // iter_end with a request in flight: result still from bank 0
        applyStimulus(1, 7'd11, 0, 1, 0);
        checkOutput("end_rd_addr", ram_rd_addr, 5);
        checkOutput("end_rd_en", ram_rd_en, 1);
        lookupWindow("inflight", 1'b1);
        checkOutput("end_rd_iter_cnt", rd_iter_cnt, 1);
        checkOutput("end_iter_ready", iter_ready, 1);
        checkOutput("end_wr_stall", wr_stall, 0);
        checkOutput("end_wr_bank", wr_bank, 0);

        // Request outside ACTIVE is dropped
        applyStimulus(1, 7'd11, 0, 0, 0);
        checkOutput("ready_req_rd_en", ram_rd_en, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ready_req_drop", lut_bus.lut_drop, 1);
        checkOutput("ready_req_valid", lut_bus.lut_valid, 0);

        // Second iteration reads bank 1 page 5 (word 2'b01), select 0
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 7'd10, 0, 0, 0);
        checkOutput("bank1_rd_addr", ram_rd_addr, 69);
        lookupWindow("bank1", 1'b1);

        // iter_end in the same cycle bank 0 is being filled: straight to READY
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        exp_wr_bank = ~exp_wr_bank;
        checkOutput("coincide_iter_ready", iter_ready, 1);
        checkOutput("coincide_rd_iter_cnt", rd_iter_cnt, 2);
        checkOutput("coincide_wr_bank", wr_bank, exp_wr_bank);

        // Run the remaining iterations to MAX_ITER
        for (int it = 2; it < MAX_ITER; it++) begin
            writerPulse();
            applyStimulus(0, 0, 1, 0, 0);
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("run_rd_iter_cnt", rd_iter_cnt, it + 1);
            checkOutput("run_decode_done", decode_done, (it + 1) == MAX_ITER);
        end

        // DONE ignores the decoder; writer flags still move
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 7'd11, 0, 0, 0);
        checkOutput("done_rd_en", ram_rd_en, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("done_decode_done", decode_done, 1);
        checkOutput("done_rd_iter_cnt", rd_iter_cnt, MAX_ITER);
        checkOutput("done_iter_ready", iter_ready, 0);
        writerPulse();

        // Reset in the middle of a lookup
        @(posedge write_clk);
        #1 rstn = 1'b0;
        @(posedge write_clk);
        #1 rstn = 1'b1;
        exp_wr_bank = 1'b0;
        writerPulse();
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 7'd11, 0, 0, 0);
        checkOutput("prereset_rd_en", ram_rd_en, 1);
        @(posedge write_clk);
        #1;
        lut_bus.lut_req = 1'b0;
        rstn = 1'b0;
        @(negedge write_clk);
        checkResetOutputs("midreset");
        @(posedge write_clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("postreset_valid", lut_bus.lut_valid, 0);
            checkOutput("postreset_iter_ready", iter_ready, 0);
            checkOutput("postreset_rd_iter_cnt", rd_iter_cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dn_ib_ram_reader.md
# dn_ib_ram_reader

Read-side controller for the double-buffered decision-node IB-RAM. The DN write unit fills one bank per iteration from IB-ROM and flags completion with `wr_iter_finish`. This block owns bank ownership and handshakes with both the writer and the decoder. It serves pipelined 1-bit LUT lookups from the bank holding the current iteration's table and counts consumed iterations up to `MAX_ITER`.

## Interface
- `SEL_BW`, 1, entry-select bits per RAM word; word width `ROM_RD_BW = 2**SEL_BW`
- `PAGE_ADDR_BW`, 6, page address bits per bank
- `ITER_ADDR_BW`, 6, iteration counter width
- `MAX_ITER`, 50, iterations per codeword
- `write_clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `wr_iter_finish`  in  1  writer's completion level; its rising edge marks `wr_bank` full
- `wr_bank`  out  1  bank the writer must fill next
- `wr_stall`  out  1  `full[wr_bank]`; writer holds while high
- `iter_ready`  out  1  `state==READY`
- `iter_start`  in  1  decoder pulse that begins an iteration
- `iter_end`  in  1  decoder pulse that ends an iteration
- `lut_req`  in  1  lookup request
- `lut_idx`  in  `PAGE_ADDR_BW+SEL_BW`  table entry index
- `lut_valid`  out  1  lookup result valid
- `lut_bit`  out  1  lookup result
- `lut_drop`  out  1  sticky flag: a request arrived outside ACTIVE
- `ram_rd_en`  out  1  IB-RAM read enable
- `ram_rd_addr`  out  `PAGE_ADDR_BW+1`  read address `{rd_bank, page}`
- `ram_rd_data`  in  `ROM_RD_BW`  IB-RAM data, valid 1 cycle after `ram_rd_en`
- `rd_iter_cnt`  out  `ITER_ADDR_BW`  completed iterations
- `decode_done`  out  1  high in DONE

## Operation
- Bank state: `full[1:0]`, `wr_bank`, `rd_bank`. Reset value 0 for each.
- On a detected rising edge of `wr_iter_finish`: set `full[wr_bank]`, toggle `wr_bank`. Edge detection uses a registered copy of `wr_iter_finish`.
- On accepted `iter_end`: clear `full[rd_bank]`, toggle `rd_bank`, increment `rd_iter_cnt`.
- A set and a clear in the same cycle always target different banks. Both take effect.
- FSM states: IDLE, READY, ACTIVE, DONE.
  - IDLE→READY when `full[rd_bank]`.
  - READY→ACTIVE on `iter_start`.
  - ACTIVE on `iter_end`: go to DONE if `rd_iter_cnt+1==MAX_ITER`; else READY if the other bank is full (or is being set this cycle); else IDLE.
  - DONE is held until reset. `iter_start`/`iter_end` are ignored there; writer flags still update.
- `iter_start` outside READY and `iter_end` outside ACTIVE are ignored.
- Lookup: `lut_req` in ACTIVE issues `ram_rd_en=1`, `ram_rd_addr={rd_bank, lut_idx[PAGE_ADDR_BW+SEL_BW-1:SEL_BW]}`. The select field `lut_idx[SEL_BW-1:0]` is pipelined alongside.
- `lut_bit = ram_rd_data[sel]`.
- Throughput: one request per cycle. Requests in flight when `iter_end` arrives complete from the old bank, because the bank is latched per request.
- `lut_req` outside ACTIVE: no RAM read, no `lut_valid`, `lut_drop` set.
- `rd_iter_cnt` saturates at `MAX_ITER`.
- Reset values: all outputs 0; state IDLE.
- Reset mid-operation clears flags, counters and the pipeline immediately. No `lut_valid` comes from pre-reset requests.

## Timing
- `ram_rd_en`/`ram_rd_addr` are combinational from `lut_req`, `lut_idx` and `state`, in the request cycle T.
- Default lookup latency: `lut_valid`/`lut_bit` registered, valid in cycle T+2.
- Rising edge of `wr_iter_finish` at cycle T: `full` is updated at T+2 (1 cycle for edge detect, 1 for the register). `iter_ready` can rise at T+3.
- `iter_start` at T: ACTIVE at T+1. The first lookup can be issued at T+1.
- `wr_stall` is combinational from the registered `full` and `wr_bank`.

## Configuration
- `DN_READ_OUTREG_EN` defined: output register stage present; latency 2 as above.
- `DN_READ_OUTREG_EN` undefined: `lut_bit` is combinational from `ram_rd_data` and the registered select; `lut_valid` is asserted at T+1; latency 1. All other behaviour is identical.

## Test plan
- Reset, then pulse `wr_iter_finish` once → `full=01`, `wr_bank=1`, `iter_ready=1`, `rd_iter_cnt=0`.
- Fill both banks without consuming → `wr_stall=1` with `wr_bank=0`. Then `iter_start`, `iter_end` → `full=10`, `rd_bank=1`, `wr_stall=0`, `rd_iter_cnt=1`, state READY.
- ACTIVE with bank 0 holding word `2'b10` at page 5: `lut_idx=11` → `ram_rd_addr=7'd5` at T, `lut_bit=1` at T+2; `lut_idx=10` → `lut_bit=0`. Back-to-back requests give consecutive results. Repeat without the macro and expect T+1.
- `iter_end` coinciding with a rising edge of `wr_iter_finish` that fills the other bank → next state READY, not IDLE.
- Run 50 write/read iterations → `rd_iter_cnt=50`, `decode_done=1`. Further `iter_start` is ignored.
- `lut_req` in READY → no `ram_rd_en`, `lut_drop=1`. Assert `rstn` low mid-lookup → `lut_valid` never asserts and all outputs read 0.
